// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 256x8 data memory.
//   slave  : arbiter side (takes requests and mem_rdata; drives ready/rvalid/rdata and mem strobes)
//   master : everything around the arbiter (requesters plus memory)
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   // port 0: core load/store path
   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_rvalid;
   logic [DATA_W-1:0] req0_rdata;
   // port 1: loader/debug path
   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_rvalid;
   logic [DATA_W-1:0] req1_rdata;
   // memory side
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_ready, req0_rvalid, req0_rdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_ready, req1_rvalid, req1_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_ready, req0_rvalid, req0_rdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_ready, req1_rvalid, req1_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing a 256x8 synchronous
// data memory. One access in flight at a time: accept in IDLE, one-cycle strobe
// in ISSUE, and for reads a RDWAIT cycle where the registered memory output is
// captured and returned to the owning port with a one-cycle rvalid pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave: req0_*/req1_* handshakes, mem_* memory port
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              owner;
   logic              op_we;

   logic              win_valid_c;
   logic              win_port_c;
   logic              win_we_c;
   logic [ADDR_W-1:0] win_addr_c;
   logic [DATA_W-1:0] win_wdata_c;

   // Winner selection: only in IDLE; on contention the port that did not go last wins.
   always_comb begin
      win_valid_c = 1'b0;
      win_port_c  = 1'b0;
      if (state == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            win_valid_c = 1'b1;
            win_port_c  = ~last_grant;
         end else if (bus.req0_valid) begin
            win_valid_c = 1'b1;
            win_port_c  = 1'b0;
         end else if (bus.req1_valid) begin
            win_valid_c = 1'b1;
            win_port_c  = 1'b1;
         end
      end
   end

   // Payload of the winning port.
   always_comb begin
      win_we_c    = bus.req0_we;
      win_addr_c  = bus.req0_addr;
      win_wdata_c = bus.req0_wdata;
      if (win_port_c) begin
         win_we_c    = bus.req1_we;
         win_addr_c  = bus.req1_addr;
         win_wdata_c = bus.req1_wdata;
      end
   end

   // Ready is combinational and only the winner sees it, so valid&ready == win_valid_c.
   assign bus.req0_ready = win_valid_c & ~win_port_c;
   assign bus.req1_ready = win_valid_c &  win_port_c;

   // Sequencer FSM with registered strobes and read-return path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         owner           <= 1'b0;
         op_we           <= 1'b0;
         bus.mem_read    <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.req0_rvalid <= 1'b0;
         bus.req0_rdata  <= '0;
         bus.req1_rvalid <= 1'b0;
         bus.req1_rdata  <= '0;
      end else begin
         // strobes and rvalid are single-cycle pulses
         bus.mem_read    <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.req0_rvalid <= 1'b0;
         bus.req1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid_c) begin
                  bus.mem_addr  <= win_addr_c;
                  bus.mem_wdata <= win_wdata_c;
                  op_we         <= win_we_c;
                  owner         <= win_port_c;
                  last_grant    <= win_port_c;
                  bus.mem_write <= win_we_c;
                  bus.mem_read  <= ~win_we_c;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               state <= op_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
               // memory output is valid this cycle; hand it to the owner only
               if (owner) begin
                  bus.req1_rdata  <= bus.mem_rdata;
                  bus.req1_rvalid <= 1'b1;
               end else begin
                  bus.req0_rdata  <= bus.mem_rdata;
                  bus.req0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants,
// memory accesses and read returns; a monitor process compares them against
// the DUT as they appear.
module tb_dmem_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural 256x8 synchronous memory with registered read data.
   logic [7:0] mem [256];
   bit         mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         bus.mem_rdata <= 8'h00;
         mem_init_done <= 1'b1;
      end else begin
         if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   typedef struct {
      int         gap;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         life;   // 0 = hold until granted, else withdraw after this many ungranted cycles
   } req_t;

   typedef struct {
      int         cyc;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } acc_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_t;

   req_t sq0[$];
   req_t sq1[$];
   req_t cur[2];
   logic pv[2];
   logic skip[2];
   acc_t accq[$];
   rd_t  rq0[$];
   rd_t  rq1[$];

   logic [7:0] ref_mem [256];
   int         last_g;
   int         next_free;
   logic [7:0] held0, held1, last_addr, last_wdata;

   int nvec = 0;
   int nerr = 0;

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      accq.delete();
      rq0.delete();
      rq1.delete();
      sq0.delete();
      sq1.delete();
      pv[0] = 1'b0; pv[1] = 1'b0;
      skip[0] = 1'b0; skip[1] = 1'b0;
      held0 = 8'h00; held1 = 8'h00;
      last_addr = 8'h00; last_wdata = 8'h00;
      last_g = 1;
      next_free = 0;
   endtask

   task automatic drive();
      bus.req0_valid = pv[0];
      bus.req0_we    = cur[0].we;
      bus.req0_addr  = cur[0].addr;
      bus.req0_wdata = cur[0].wdata;
      bus.req1_valid = pv[1];
      bus.req1_we    = cur[1].we;
      bus.req1_addr  = cur[1].addr;
      bus.req1_wdata = cur[1].wdata;
   endtask

   task automatic load_port0();
      req_t e;
      if (skip[0]) skip[0] = 1'b0;
      else if (!pv[0] && sq0.size() != 0) begin
         if (sq0[0].gap != 0) begin e = sq0[0]; e.gap--; sq0[0] = e; end
         else begin cur[0] = sq0.pop_front(); pv[0] = 1'b1; end
      end
   endtask

   task automatic load_port1();
      req_t e;
      if (skip[1]) skip[1] = 1'b0;
      else if (!pv[1] && sq1.size() != 0) begin
         if (sq1[0].gap != 0) begin e = sq1[0]; e.gap--; sq1[0] = e; end
         else begin cur[1] = sq1.pop_front(); pv[1] = 1'b1; end
      end
   endtask

   // Transaction model: one access at a time; write busy 2 cycles, read 3; round robin on contention.
   task automatic model();
      int   w;
      acc_t a;
      rd_t  r;
      w = -1;
      if (cyc >= next_free) begin
         if (pv[0] && pv[1]) w = (last_g == 0) ? 1 : 0;
         else if (pv[0])     w = 0;
         else if (pv[1])     w = 1;
      end
      chk("ready0", bus.req0_ready, (w == 0));
      chk("ready1", bus.req1_ready, (w == 1));
      if (w >= 0) begin
         a.cyc = cyc + 1; a.we = cur[w].we; a.addr = cur[w].addr; a.wdata = cur[w].wdata;
         accq.push_back(a);
         if (cur[w].we) begin
            ref_mem[cur[w].addr] = cur[w].wdata;
            next_free = cyc + 2;
         end else begin
            r.cyc = cyc + 3; r.data = ref_mem[cur[w].addr];
            if (w == 0) rq0.push_back(r); else rq1.push_back(r);
            next_free = cyc + 3;
         end
         last_g = w;
         pv[w] = 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
         if (pv[n] && cur[n].life != 0) begin
            cur[n].life--;
            if (cur[n].life == 0) begin pv[n] = 1'b0; skip[n] = 1'b1; end
         end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      load_port0();
      load_port1();
      drive();
      @(negedge clk);
      model();
   endtask

   task automatic run_until_idle(input int max);
      int n;
      n = 0;
      while ((sq0.size() != 0 || sq1.size() != 0 || pv[0] || pv[1] || cyc < next_free + 4) && n < max) begin
         step();
         n++;
      end
      if (n >= max) fail("drain_timeout", n, max);
   endtask

   task automatic push_req(input int port, input int gap, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata, input int life);
      req_t e;
      e.gap = gap; e.we = we; e.addr = addr; e.wdata = wdata; e.life = life;
      if (port == 0) sq0.push_back(e); else sq1.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_read"},  bus.mem_read,    0);
      chk({tag, "_mem_write"}, bus.mem_write,   0);
      chk({tag, "_mem_addr"},  bus.mem_addr,    0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,   0);
      chk({tag, "_rvalid0"},   bus.req0_rvalid, 0);
      chk({tag, "_rvalid1"},   bus.req1_rvalid, 0);
      chk({tag, "_rdata0"},    bus.req0_rdata,  0);
      chk({tag, "_rdata1"},    bus.req1_rdata,  0);
      chk({tag, "_ready0"},    bus.req0_ready,  0);
      chk({tag, "_ready1"},    bus.req1_ready,  0);
   endtask

   // Monitor: compares memory strobes and read returns against the expected queues.
   initial begin
      acc_t a;
      rd_t  r;
      forever begin
         @(negedge clk);
         chk("strobe_excl", bus.mem_read & bus.mem_write, 0);
         if (accq.size() != 0 && accq[0].cyc < cyc) begin
            a = accq.pop_front();
            fail("access_missing", a.addr, a.cyc);
         end
         if (bus.mem_read || bus.mem_write) begin
            if (accq.size() == 0) fail("access_unexpected", bus.mem_addr, {bus.mem_write, bus.mem_read});
            else begin
               a = accq.pop_front();
               chk("access_cycle", cyc, a.cyc);
               chk("mem_write", bus.mem_write, a.we);
               chk("mem_read", bus.mem_read, !a.we);
               chk("mem_addr", bus.mem_addr, a.addr);
               chk("mem_wdata", bus.mem_wdata, a.wdata);
               last_addr  = a.addr;
               last_wdata = a.wdata;
            end
         end else begin
            chk("mem_addr_hold", bus.mem_addr, last_addr);
            chk("mem_wdata_hold", bus.mem_wdata, last_wdata);
         end
         if (rq0.size() != 0 && rq0[0].cyc < cyc) begin
            r = rq0.pop_front();
            fail("rvalid0_missing", 0, r.cyc);
         end
         if (bus.req0_rvalid) begin
            if (rq0.size() == 0) fail("rvalid0_unexpected", bus.req0_rvalid, 0);
            else begin
               r = rq0.pop_front();
               chk("rvalid0_cycle", cyc, r.cyc);
               chk("rdata0", bus.req0_rdata, r.data);
               held0 = r.data;
            end
         end
         chk("rdata0_hold", bus.req0_rdata, held0);
         if (rq1.size() != 0 && rq1[0].cyc < cyc) begin
            r = rq1.pop_front();
            fail("rvalid1_missing", 0, r.cyc);
         end
         if (bus.req1_rvalid) begin
            if (rq1.size() == 0) fail("rvalid1_unexpected", bus.req1_rvalid, 0);
            else begin
               r = rq1.pop_front();
               chk("rvalid1_cycle", cyc, r.cyc);
               chk("rdata1", bus.req1_rdata, r.data);
               held1 = r.data;
            end
         end
         chk("rdata1_hold", bus.req1_rdata, held1);
      end
   end

   initial begin
      req_t z;
      z.gap = 0; z.we = 1'b0; z.addr = 8'h00; z.wdata = 8'h00; z.life = 0;
      cur[0] = z; cur[1] = z;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      reset_model();
      drive();

      // reset state
      repeat (2) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst_n = 1'b1;

      // port 0 write 0x10=0xA5, then read it back
      push_req(0, 0, 1'b1, 8'h10, 8'hA5, 0);
      push_req(0, 0, 1'b0, 8'h10, 8'h00, 0);
      run_until_idle(100);
      chk("rdata0_a5", bus.req0_rdata, 8'hA5);

      // fairness from reset: both ports hammer writes
      @(posedge clk); #3; rst_n = 1'b0; reset_model(); drive();
      @(posedge clk); #3; rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_req(0, 0, 1'b1, 8'h01, 8'h11, 0);
         push_req(1, 0, 1'b1, 8'h02, 8'h22, 0);
      end
      run_until_idle(200);
      chk("mem_01", mem[1], 8'h11);
      chk("mem_02", mem[2], 8'h22);

      // contending reads; last grant was port 1 so port 0 goes first
      push_req(0, 0, 1'b0, 8'h01, 8'h00, 0);
      push_req(1, 0, 1'b0, 8'h02, 8'h00, 0);
      run_until_idle(200);
      chk("rdata0_11", bus.req0_rdata, 8'h11);
      chk("rdata1_22", bus.req1_rdata, 8'h22);

      // port 1 withdraws while port 0 is busy
      push_req(0, 0, 1'b0, 8'h10, 8'h00, 0);
      push_req(1, 1, 1'b1, 8'h30, 8'h77, 2);
      run_until_idle(200);
      chk("withdraw_no_write", mem[8'h30], 8'h00);

      // reset during RDWAIT of a port 0 read
      push_req(0, 0, 1'b0, 8'h10, 8'h00, 0);
      step();
      step();
      step();
      #1;
      pv[0] = 1'b0; pv[1] = 1'b0;
      drive();
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      reset_model();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      push_req(0, 0, 1'b1, 8'h20, 8'h33, 0);
      push_req(1, 0, 1'b1, 8'h21, 8'h44, 0);
      run_until_idle(200);
      chk("post_rst_mem20", mem[8'h20], 8'h33);

      // randomized traffic on both ports
      for (int k = 0; k < 150; k++) begin
         push_req(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
         push_req(1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_until_idle(20000);

      chk("accq_empty", accq.size(), 0);
      chk("rq0_empty", rq0.size(), 0);
      chk("rq1_empty", rq1.size(), 0);
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 synchronous data memory (mem_read/mem_write strobes, one-cycle registered read data).
- Port 0 is the core load/store path; port 1 is the loader/debug path.
- Grants one access at a time using round-robin priority.
- Drives registered memory strobes and address/data, and returns read data to the owning requester with a valid pulse.

Parameters:
- ADDR_W, 8, memory address width (256 locations).
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 access request.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_rvalid  out  1  port 0 read data valid, 1-cycle pulse.
- req0_rdata  out  DATA_W  port 0 read data, held until the next port 0 read returns.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as port 0, for port 1.
- mem_read  out  1  read strobe to memory.
- mem_write  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  registered memory read output.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (so port 0 wins first), all outputs 0, owner/op latches cleared. Memory contents are not touched.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE:
  - reqN_ready is combinational and is high only for the winner, only in IDLE.
  - Winner when only one port is valid: that port.
  - Winner when both are valid: the port not equal to last_grant.
  - Handshake is valid&ready. On handshake: latch addr/wdata/we into mem_addr/mem_wdata, record owner, set last_grant=owner, go to ISSUE.
  - No valid request: stay in IDLE, both ready=0.
- ISSUE:
  - mem_write=we or mem_read=!we, high for exactly this one cycle (registered). The memory samples them at the end of the cycle.
  - Write: next state is IDLE.
  - Read: next state is RDWAIT.
- RDWAIT:
  - mem_rdata is valid this cycle. Capture it into reqOwner_rdata at the cycle end.
  - Pulse reqOwner_rvalid for the following cycle. The FSM returns to IDLE in that same cycle, so a new accept may coincide with rvalid.
- Timing:
  - Write: accept at edge E0, strobe during E0..E1. Write throughput is 1 per 2 cycles.
  - Read: rvalid asserted 3 cycles after accept. Read throughput is 1 per 3 cycles.
- Strobe exclusivity: mem_read and mem_write are never high together, and both are low in IDLE and RDWAIT.
- Latching: mem_addr/mem_wdata hold their last value outside ISSUE. Requester inputs are sampled only at the handshake edge; later changes have no effect.
- Requester rules:
  - A requester holds valid and payload stable until ready.
  - Dropping valid before ready withdraws the request, with no side effect.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1. Neither port waits more than one other access.
- Data routing: the rdata/rvalid of the non-owner port are unaffected by the other port's read.
- Reset mid-operation: the in-flight access is abandoned.
  - If asserted in ISSUE, the strobe drops immediately (async). Whether the memory write lands depends on whether the reset precedes the memory's clock edge; this is not guaranteed.
  - No rvalid is ever produced for an abandoned read.
  - After release: IDLE with port 0 priority.

Test Plan:
- Port 0 write: addr=0x10, wdata=0xA5 -> req0_ready in cycle 0; next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xA5, mem_read=0; ready again 2 cycles after accept.
- Port 0 read of 0x10 after the above, with a behavioural 256x8 memory model -> mem_read pulse 1 cycle after accept; req0_rvalid=1 with req0_rdata=0xA5 exactly 3 cycles after accept; req1_rvalid stays 0.
- Both ports valid continuously from reset (p0 write 0x01=0x11, p1 write 0x02=0x22, repeated) -> grants p0, p1, p0, p1; memory holds 0x11@0x01 and 0x22@0x02.
- Port 1 read 0x02 while port 0 read 0x01 is pending -> p0 granted first; req0_rdata=0x11, then req1_rdata=0x22; each rvalid is a single-cycle pulse to the correct port.
- Assert rst_n=0 during RDWAIT of a port 0 read -> all outputs 0 immediately; no req0_rvalid after release; the first post-reset contention is won by port 0.
- Port 1 drops valid before being granted (port 0 busy) -> no access issued for port 1; mem strobes show only port 0 traffic.
